// File: rtl/rob_pkg.sv
// Shared constants and the entry payload type for the reorder buffer.
package rob_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int TAG_W     = 4;
    localparam int COUNT_W   = TAG_W + 1;
    localparam int RD_W      = 5;
    localparam int DATA_W    = 32;

    localparam logic [RD_W-1:0] ZERO_REG = '0;

    typedef logic [TAG_W-1:0] tag_t;

    // Entry payload. The valid and ready flags are kept outside the struct
    // so they can be reset on their own.
    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] value;
        logic              is_branch;
        logic              is_store;
        logic              mispredict;
        logic [DATA_W-1:0] redirect_pc;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: hands out rename tags, captures CDB
// results, retires in program order and drives the register-file commit
// and flush interface.
module reorder_buffer
    import rob_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              alloc_valid,
    input  logic [RD_W-1:0]   alloc_rd,
    input  logic              alloc_is_branch,
    input  logic              alloc_is_store,
    output logic [TAG_W-1:0]  alloc_tag,
    output logic              rob_full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic              cdb_mispredict,
    input  logic [DATA_W-1:0] cdb_redirect_pc,
    input  logic [TAG_W-1:0]  query_tag_1,
    input  logic [TAG_W-1:0]  query_tag_2,
    output logic              query_ready_1,
    output logic              query_ready_2,
    output logic [DATA_W-1:0] query_value_1,
    output logic [DATA_W-1:0] query_value_2,
    output logic              register_update_flag,
    output logic [RD_W-1:0]   register_commit_dest,
    output logic [DATA_W-1:0] register_commit_value,
    output logic [TAG_W-1:0]  rename_of_commit_ins,
    output logic              register_flush,
    output logic [DATA_W-1:0] flush_pc,
    output logic              store_commit,
    output logic [TAG_W-1:0]  store_commit_tag
);

    rob_entry_t           entries [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] valid;
    logic [ROB_DEPTH-1:0] ready;
    tag_t                 head;
    tag_t                 tail;
    logic [COUNT_W-1:0]   count;

    rob_entry_t head_entry;
    logic       commit_fire;
    logic       do_flush;
    logic       do_alloc;
    logic       do_wb;

    assign alloc_tag = tail;
    assign rob_full  = (count == COUNT_W'(ROB_DEPTH));

    // Query ports forward stored results only; the RS snoops the CDB itself.
    assign query_ready_1 = valid[query_tag_1] && ready[query_tag_1];
    assign query_ready_2 = valid[query_tag_2] && ready[query_tag_2];
    assign query_value_1 = entries[query_tag_1].value;
    assign query_value_2 = entries[query_tag_2].value;

    // Decode this cycle's commit, flush, allocation and writeback from registered state.
    always_comb begin
        head_entry  = entries[head];
        commit_fire = valid[head] && ready[head];
        do_flush    = commit_fire && head_entry.is_branch && head_entry.mispredict;
        do_alloc    = alloc_valid && !rob_full && !do_flush;
        do_wb       = cdb_valid && valid[cdb_tag] && !do_flush;
    end

    // Entry payload storage.
    // NOTE: the payload array has no reset; an entry is only ever read while its
    // valid bit is set, and every allocation rewrites the fields that matter.
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (do_alloc) begin
                entries[tail].rd         <= alloc_rd;
                entries[tail].is_branch  <= alloc_is_branch;
                entries[tail].is_store   <= alloc_is_store;
                entries[tail].mispredict <= 1'b0;
            end
            if (do_wb) begin
                entries[cdb_tag].value       <= cdb_value;
                entries[cdb_tag].mispredict  <= cdb_mispredict;
                entries[cdb_tag].redirect_pc <= cdb_redirect_pc;
            end
        end
    end

    // Pointers, valid/ready flags and the registered commit/flush/store outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            head                  <= '0;
            tail                  <= '0;
            count                 <= '0;
            valid                 <= '0;
            ready                 <= '0;
            register_update_flag  <= 1'b0;
            register_commit_dest  <= '0;
            register_commit_value <= '0;
            rename_of_commit_ins  <= '0;
            register_flush        <= 1'b0;
            flush_pc              <= '0;
            store_commit          <= 1'b0;
            store_commit_tag      <= '0;
        end else if (rdy) begin
            // NOTE: later non-blocking writes to the same bit win, so the
            // commit clear below overrides an allocate or writeback to head.
            register_update_flag <= 1'b0;
            register_flush       <= 1'b0;
            store_commit         <= 1'b0;
            if (do_flush) begin
                valid          <= '0;
                ready          <= '0;
                head           <= '0;
                tail           <= '0;
                count          <= '0;
                register_flush <= 1'b1;
                flush_pc       <= head_entry.redirect_pc;
            end else begin
                if (do_alloc) begin
                    valid[tail] <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= tail + 4'd1;
                end
                if (do_wb) begin
                    ready[cdb_tag] <= 1'b1;
                end
                if (commit_fire) begin
                    valid[head] <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head + 4'd1;
                    if (head_entry.is_store) begin
                        store_commit     <= 1'b1;
                        store_commit_tag <= head;
                    end else if (!head_entry.is_branch && head_entry.rd != ZERO_REG) begin
                        register_update_flag  <= 1'b1;
                        register_commit_dest  <= head_entry.rd;
                        register_commit_value <= head_entry.value;
                        rename_of_commit_ins  <= head;
                    end
                end
                count <= count + COUNT_W'(do_alloc) - COUNT_W'(commit_fire);
            end
        end else begin
            // Frozen: hold state but drop pulses so none is seen twice.
            register_update_flag <= 1'b0;
            register_flush       <= 1'b0;
            store_commit         <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: in-order commit, full/wrap, mispredict
// flush, rd=0 commit, store commit and rdy freeze.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic        alloc_is_branch;
    logic        alloc_is_store;
    logic [3:0]  alloc_tag;
    logic        rob_full;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        cdb_mispredict;
    logic [31:0] cdb_redirect_pc;
    logic [3:0]  query_tag_1;
    logic [3:0]  query_tag_2;
    logic        query_ready_1;
    logic        query_ready_2;
    logic [31:0] query_value_1;
    logic [31:0] query_value_2;
    logic        register_update_flag;
    logic [4:0]  register_commit_dest;
    logic [31:0] register_commit_value;
    logic [3:0]  rename_of_commit_ins;
    logic        register_flush;
    logic [31:0] flush_pc;
    logic        store_commit;
    logic [3:0]  store_commit_tag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk                   (clk),
        .rst                   (rst),
        .rdy                   (rdy),
        .alloc_valid           (alloc_valid),
        .alloc_rd              (alloc_rd),
        .alloc_is_branch       (alloc_is_branch),
        .alloc_is_store        (alloc_is_store),
        .alloc_tag             (alloc_tag),
        .rob_full              (rob_full),
        .cdb_valid             (cdb_valid),
        .cdb_tag               (cdb_tag),
        .cdb_value             (cdb_value),
        .cdb_mispredict        (cdb_mispredict),
        .cdb_redirect_pc       (cdb_redirect_pc),
        .query_tag_1           (query_tag_1),
        .query_tag_2           (query_tag_2),
        .query_ready_1         (query_ready_1),
        .query_ready_2         (query_ready_2),
        .query_value_1         (query_value_1),
        .query_value_2         (query_value_2),
        .register_update_flag  (register_update_flag),
        .register_commit_dest  (register_commit_dest),
        .register_commit_value (register_commit_value),
        .rename_of_commit_ins  (rename_of_commit_ins),
        .register_flush        (register_flush),
        .flush_pc              (flush_pc),
        .store_commit          (store_commit),
        .store_commit_tag      (store_commit_tag)
    );

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid     = 1'b0;
        alloc_rd        = '0;
        alloc_is_branch = 1'b0;
        alloc_is_store  = 1'b0;
        cdb_valid       = 1'b0;
        cdb_tag         = '0;
        cdb_value       = '0;
        cdb_mispredict  = 1'b0;
        cdb_redirect_pc = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rdy = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic br, input logic st);
        alloc_valid     = 1'b1;
        alloc_rd        = rd;
        alloc_is_branch = br;
        alloc_is_store  = st;
        tick();
        alloc_valid     = 1'b0;
        alloc_is_branch = 1'b0;
        alloc_is_store  = 1'b0;
    endtask

    task automatic set_wb(input logic [3:0] tag, input logic [31:0] val,
                          input logic mp, input logic [31:0] pc);
        cdb_valid       = 1'b1;
        cdb_tag         = tag;
        cdb_value       = val;
        cdb_mispredict  = mp;
        cdb_redirect_pc = pc;
    endtask

    task automatic test_reset();
        query_tag_1 = 4'd0;
        query_tag_2 = 4'd5;
        do_reset();
        total++;
        if ({alloc_tag, rob_full} !== {4'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_ptr: got tag=%0d full=%0b want tag=0 full=0", alloc_tag, rob_full);
        end
        total++;
        if ({register_update_flag, register_flush, store_commit} !== 3'b000) begin
            bad++;
            $display("FAIL reset_pulses: got upd=%0b flush=%0b st=%0b want 0", register_update_flag, register_flush, store_commit);
        end
        total++;
        if ({register_commit_dest, register_commit_value, rename_of_commit_ins, flush_pc, store_commit_tag} !== 77'd0) begin
            bad++;
            $display("FAIL reset_data: dest=%0d val=%h tag=%0d pc=%h stag=%0d want all 0", register_commit_dest, register_commit_value, rename_of_commit_ins, flush_pc, store_commit_tag);
        end
        total++;
        if ({query_ready_1, query_ready_2} !== 2'b00) begin
            bad++;
            $display("FAIL reset_query: got %b want 00", {query_ready_1, query_ready_2});
        end
    endtask

    task automatic test_in_order();
        logic [3:0] exp_tag [3];
        logic [4:0] rds [3];
        rds[0] = 5'd5; rds[1] = 5'd6; rds[2] = 5'd7;
        exp_tag[0] = 4'd0; exp_tag[1] = 4'd1; exp_tag[2] = 4'd2;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (alloc_tag !== exp_tag[i]) begin
                bad++;
                $display("FAIL inorder_alloc_tag%0d: got %0d want %0d", i, alloc_tag, exp_tag[i]);
            end
            alloc(rds[i], 1'b0, 1'b0);
        end
        set_wb(4'd1, 32'h22, 1'b0, 32'h0);
        tick();
        query_tag_1 = 4'd1;
        query_tag_2 = 4'd0;
        #1;
        total++;
        if ({query_ready_1, query_value_1, query_ready_2, register_update_flag} !== {1'b1, 32'h22, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL inorder_query: got rdy1=%0b val1=%h rdy0=%0b upd=%0b want 1 22 0 0", query_ready_1, query_value_1, query_ready_2, register_update_flag);
        end
        set_wb(4'd0, 32'h11, 1'b0, 32'h0);
        tick();
        cdb_valid = 1'b0;
        total++;
        if (register_update_flag !== 1'b0) begin
            bad++;
            $display("FAIL inorder_wb_same_edge: got upd=%0b want 0", register_update_flag);
        end
        tick();
        total++;
        if ({register_update_flag, register_commit_dest, register_commit_value, rename_of_commit_ins} !== {1'b1, 5'd5, 32'h11, 4'd0}) begin
            bad++;
            $display("FAIL inorder_commit0: got upd=%0b rd=%0d val=%h tag=%0d want 1 5 11 0", register_update_flag, register_commit_dest, register_commit_value, rename_of_commit_ins);
        end
        tick();
        total++;
        if ({register_update_flag, register_commit_dest, register_commit_value, rename_of_commit_ins} !== {1'b1, 5'd6, 32'h22, 4'd1}) begin
            bad++;
            $display("FAIL inorder_commit1: got upd=%0b rd=%0d val=%h tag=%0d want 1 6 22 1", register_update_flag, register_commit_dest, register_commit_value, rename_of_commit_ins);
        end
        tick();
        total++;
        if ({register_update_flag, alloc_tag} !== {1'b0, 4'd3}) begin
            bad++;
            $display("FAIL inorder_tag2_held: got upd=%0b tail=%0d want 0 3", register_update_flag, alloc_tag);
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc(5'(i + 1), 1'b0, 1'b0);
        end
        total++;
        if ({rob_full, alloc_tag} !== {1'b1, 4'd0}) begin
            bad++;
            $display("FAIL full_16: got full=%0b tail=%0d want 1 0", rob_full, alloc_tag);
        end
        alloc(5'd9, 1'b0, 1'b0);
        total++;
        if ({rob_full, alloc_tag} !== {1'b1, 4'd0}) begin
            bad++;
            $display("FAIL full_17th_ignored: got full=%0b tail=%0d want 1 0", rob_full, alloc_tag);
        end
        set_wb(4'd0, 32'hA0, 1'b0, 32'h0);
        tick();
        cdb_valid = 1'b0;
        // Commit and a request in the same cycle: full before the edge, so refused.
        alloc(5'd9, 1'b0, 1'b0);
        total++;
        if ({register_update_flag, register_commit_dest, register_commit_value, rob_full, alloc_tag} !== {1'b1, 5'd1, 32'hA0, 1'b0, 4'd0}) begin
            bad++;
            $display("FAIL full_commit_refuse: got upd=%0b rd=%0d val=%h full=%0b tail=%0d want 1 1 a0 0 0", register_update_flag, register_commit_dest, register_commit_value, rob_full, alloc_tag);
        end
        alloc(5'd9, 1'b0, 1'b0);
        query_tag_1 = 4'd0;
        #1;
        total++;
        if ({rob_full, alloc_tag, query_ready_1} !== {1'b1, 4'd1, 1'b0}) begin
            bad++;
            $display("FAIL full_wrap_alloc: got full=%0b tail=%0d rdy0=%0b want 1 1 0", rob_full, alloc_tag, query_ready_1);
        end
    endtask

    task automatic test_flush();
        logic [4:0] seen_upd;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            alloc(5'(i + 1), (i == 3), 1'b0);
        end
        set_wb(4'd4, 32'h44, 1'b0, 32'h0);   tick();
        set_wb(4'd3, 32'h0, 1'b1, 32'h1000); tick();
        set_wb(4'd0, 32'h10, 1'b0, 32'h0);   tick();
        set_wb(4'd1, 32'h11, 1'b0, 32'h0);   tick();
        set_wb(4'd2, 32'h12, 1'b0, 32'h0);   tick();
        total++;
        if ({register_update_flag, register_commit_dest} !== {1'b1, 5'd2}) begin
            bad++;
            $display("FAIL flush_pre_commit: got upd=%0b rd=%0d want 1 2", register_update_flag, register_commit_dest);
        end
        cdb_valid = 1'b0;
        tick();   // commits tag2
        alloc_valid = 1'b1;
        alloc_rd    = 5'd20;
        tick();   // branch commits; flush discards this allocation
        alloc_valid = 1'b0;
        query_tag_1 = 4'd4;
        #1;
        total++;
        if ({register_flush, flush_pc, register_update_flag, alloc_tag, rob_full, query_ready_1} !== {1'b1, 32'h1000, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL flush_pulse: got fl=%0b pc=%h upd=%0b tail=%0d full=%0b rdy4=%0b want 1 1000 0 0 0 0", register_flush, flush_pc, register_update_flag, alloc_tag, rob_full, query_ready_1);
        end
        seen_upd = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen_upd[i] = register_update_flag | register_flush | store_commit;
        end
        total++;
        if (seen_upd !== 5'b0) begin
            bad++;
            $display("FAIL flush_no_younger_commit: got pulses=%b want 00000", seen_upd);
        end
    endtask

    task automatic test_rd_zero();
        do_reset();
        alloc(5'd0, 1'b0, 1'b0);
        alloc(5'd7, 1'b0, 1'b0);
        set_wb(4'd0, 32'hDEAD, 1'b0, 32'h0); tick();
        cdb_valid = 1'b0;
        tick();
        total++;
        if (register_update_flag !== 1'b0) begin
            bad++;
            $display("FAIL rd0_no_update: got upd=%0b want 0", register_update_flag);
        end
        set_wb(4'd1, 32'h77, 1'b0, 32'h0); tick();
        cdb_valid = 1'b0;
        tick();
        total++;
        if ({register_update_flag, register_commit_dest, register_commit_value, rename_of_commit_ins} !== {1'b1, 5'd7, 32'h77, 4'd1}) begin
            bad++;
            $display("FAIL rd0_head_advanced: got upd=%0b rd=%0d val=%h tag=%0d want 1 7 77 1", register_update_flag, register_commit_dest, register_commit_value, rename_of_commit_ins);
        end
    endtask

    task automatic test_store();
        do_reset();
        alloc(5'd0, 1'b0, 1'b0);
        alloc(5'd3, 1'b0, 1'b1);
        set_wb(4'd0, 32'h1, 1'b0, 32'h0); tick();
        set_wb(4'd1, 32'h55, 1'b0, 32'h0); tick();
        cdb_valid = 1'b0;
        total++;
        if ({store_commit, register_update_flag} !== 2'b00) begin
            bad++;
            $display("FAIL store_early: got st=%0b upd=%0b want 0 0", store_commit, register_update_flag);
        end
        tick();
        total++;
        if ({store_commit, store_commit_tag, register_update_flag} !== {1'b1, 4'd1, 1'b0}) begin
            bad++;
            $display("FAIL store_commit: got st=%0b tag=%0d upd=%0b want 1 1 0", store_commit, store_commit_tag, register_update_flag);
        end
        tick();
        total++;
        if (store_commit !== 1'b0) begin
            bad++;
            $display("FAIL store_pulse_width: got st=%0b want 0", store_commit);
        end
    endtask

    task automatic test_rdy_hold();
        logic [2:0] frozen;
        do_reset();
        alloc(5'd9, 1'b0, 1'b0);
        set_wb(4'd0, 32'h99, 1'b0, 32'h0); tick();
        cdb_valid   = 1'b0;
        rdy         = 1'b0;
        alloc_valid = 1'b1;
        alloc_rd    = 5'd4;
        frozen      = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            frozen[i] = register_update_flag | store_commit | register_flush;
        end
        total++;
        if ({frozen, alloc_tag} !== {3'b000, 4'd1}) begin
            bad++;
            $display("FAIL rdy_freeze: got pulses=%b tail=%0d want 000 1", frozen, alloc_tag);
        end
        alloc_valid = 1'b0;
        rdy = 1'b1;
        tick();
        total++;
        if ({register_update_flag, register_commit_dest, register_commit_value} !== {1'b1, 5'd9, 32'h99}) begin
            bad++;
            $display("FAIL rdy_release_commit: got upd=%0b rd=%0d val=%h want 1 9 99", register_update_flag, register_commit_dest, register_commit_value);
        end
        rdy = 1'b0;
        tick();
        total++;
        if (register_update_flag !== 1'b0) begin
            bad++;
            $display("FAIL rdy_low_clears_pulse: got upd=%0b want 0", register_update_flag);
        end
        rdy = 1'b1;
        tick();
        total++;
        if (register_update_flag !== 1'b0) begin
            bad++;
            $display("FAIL rdy_single_pulse: got upd=%0b want 0", register_update_flag);
        end
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        query_tag_1 = '0;
        query_tag_2 = '0;
        idle_inputs();
        test_reset();
        test_in_order();
        test_full_wrap();
        test_flush();
        test_rd_zero();
        test_store();
        test_rdy_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000ns");
        $fatal(1);
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

16-entry circular reorder buffer for the Tomasulo core. It hands out 4-bit rename tags at issue and captures results broadcast on the CDB. It retires entries strictly in program order, driving the register file's commit port (update flag, destination, value, rename tag) and its flush input. It is the transmitting end of the register-file commit/flush interface.

## Interface
- ROB_DEPTH, 16, number of entries; fixed by the 4-bit rename tag width
- TAG_W, 4, rename tag width
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low freezes all state
- alloc_valid  in  1  issue requests an entry this cycle
- alloc_rd  in  5  destination register (0 = none)
- alloc_is_branch  in  1  entry is a branch
- alloc_is_store  in  1  entry is a store
- alloc_tag  out  4  tag granted to the current request; equals the tail pointer
- rob_full  out  1  combinational; count == 16
- cdb_valid  in  1  result broadcast
- cdb_tag  in  4  producing entry
- cdb_value  in  32  result value
- cdb_mispredict  in  1  branch resolved opposite to its prediction
- cdb_redirect_pc  in  32  correct next PC for a branch
- query_tag_1, query_tag_2  in  4  operand lookup from the RS
- query_ready_1, query_ready_2  out  1  combinational; entry is valid and ready
- query_value_1, query_value_2  out  32  combinational; entry value
- register_update_flag  out  1  commit pulse to the register file
- register_commit_dest  out  5  committed rd
- register_commit_value  out  32  committed value
- rename_of_commit_ins  out  4  tag of the committed entry
- register_flush  out  1  flush pulse to the register file, RS and predictor
- flush_pc  out  32  redirect target
- store_commit  out  1  pulse telling the LSB to perform its oldest store
- store_commit_tag  out  4  tag of that store

## Operation
- Per-entry state: valid, ready, rd, value, is_branch, is_store, mispredict, redirect_pc. Pointers: head, tail (4 bits, wrap 15→0). Count is 5 bits.
- Allocate: if alloc_valid && !rob_full, entry[tail] is written with valid=1, ready=0, tail++, count++. If the ROB is full, the request is ignored; issue must stall on rob_full.
- Writeback: if cdb_valid && entry[cdb_tag].valid, set ready=1 and store value, mispredict and redirect_pc. A writeback to an invalid entry is ignored.
- Commit: at most one per cycle. It occurs when entry[head] is valid and ready as registered at the start of the cycle. On commit:
  - entry cleared; head++, count--.
  - Non-branch, non-store with rd≠0: register_update_flag=1, with dest, value and tag driven.
  - rd=0: no update pulse.
  - Store: store_commit=1, store_commit_tag=head.
  - Branch without mispredict: nothing external.
  - Branch with mispredict: register_flush=1, flush_pc=redirect_pc. All valid bits clear; head=tail=count=0. A same-cycle allocation and writeback are discarded.
- Simultaneous alloc + commit: count is unchanged. rob_full is evaluated on pre-edge count, so a full ROB refuses allocation even when it also commits that cycle.
- Writeback to the head entry in the same cycle: commit happens next cycle, not this one.
- Query path: it forwards the stored value only. It does not bypass the current CDB; the RS snoops the CDB itself.

## Timing
- Reset values: head=tail=count=0; all valid=0; all pulse outputs 0; register_commit_dest, register_commit_value, rename_of_commit_ins, flush_pc and store_commit_tag all 0.
- All commit, flush and store outputs are registered single-cycle pulses. They are cleared on any rdy-high edge with no event.
- When rdy=0, no state changes, and the pulse outputs are forced to 0 at that edge so a stale pulse cannot be seen twice.
- Latency:
  - alloc → writeback-able: next edge.
  - writeback → commit pulse: earliest 2 edges (ready registered, then commit registered).
  - Mispredicted branch ready → register_flush: same 2 edges.
- Flush has priority over alloc, writeback and queries in its cycle. rst has priority over everything.

## Structure
- rob_pkg holds ROB_DEPTH, TAG_W, the entry struct/field widths, and the zero-register constant.
- Single module; the entry array is inline. No sub-module is needed.

## Test plan
- Reset, then allocate 3 entries with rd=5,6,7 → alloc_tag 0,1,2. Writeback tag1=0x22, then tag0=0x11 → commits in order: (5,0x11,tag0) then (6,0x22,tag1); tag2 stays uncommitted.
- Allocate 16 entries → rob_full=1 and a 17th alloc is ignored. Commit one, then allocate → tag wraps to 0, count=16.
- Branch at tag3 resolves with cdb_mispredict=1, redirect 0x1000 → register_flush=1, flush_pc=0x1000. The next alloc_tag is 0, and younger ready entries never produce a commit.
- Entry with rd=0 written back → head advances, register_update_flag stays 0.
- Store entry ready at head → store_commit=1 with its tag, and no register update.
- Hold rdy=0 for 3 cycles while the head is ready → no pulses. When rdy goes high, exactly one commit pulse is produced.
